// File: rtl/parity_pkg.sv
// Shared definitions for the parity framing transmitter.
//   state_e   : frame FSM states (IDLE, START, DATA, PARITY, STOP), 3 bits
//   LINE_IDLE : serial line level when no frame is in progress (also the stop bit)
//   START_LVL : serial line level of the start bit
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator.
//   data    [DATA_W-1:0] : word to protect
//   odd_sel              : 1 = odd parity, 0 = even parity
//   par_bit              : bit that makes the count of ones (data + par_bit)
//                          odd (odd_sel=1) or even (odd_sel=0)
module parity_calc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              par_bit
);

  always_comb begin
    par_bit = odd_sel ? ~^data : ^data;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// UART-style frame transmitter with per-word odd/even parity.
// Frame on tx_out: start(0), DATA_W data bits LSB first, parity, stop(1);
// every bit is held CLKS_PER_BIT cycles.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : producer offers in_data / par_odd
//   in_data     : word to transmit
//   par_odd     : parity sense sampled with the word (1 = odd, 0 = even)
//   in_ready    : word accepted on this edge when in_valid is also high
//   tx_out      : registered serial line, idles at 1
//   busy        : a frame is in progress
//   frame_done  : one-cycle pulse on the last cycle of each stop bit
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              par_odd,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              par_new;
  logic              last_cyc;

  parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .data    (in_data),
    .odd_sel (par_odd),
    .par_bit (par_new)
  );

  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign tx_out     = tx_q;
  assign frame_done = done_q;
  assign last_cyc   = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q != IDLE) begin
      cyc_d = last_cyc ? '0 : cyc_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_d = in_data;
          par_d   = par_new;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last_cyc) state_d = DATA;
      end
      DATA: begin
        if (last_cyc) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (last_cyc) state_d = STOP;
      end
      STOP: begin
        if (last_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and done pulse are computed from the next state so the
  // registered outputs line up with state_q in the following cycle.
  always_comb begin
    tx_d = LINE_IDLE;
    unique case (state_d)
      IDLE:    tx_d = LINE_IDLE;
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = LINE_IDLE;
      default: tx_d = LINE_IDLE;
    endcase
    done_d = (state_d == STOP) && (cyc_d == CYC_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: one instance at CLKS_PER_BIT=1 for
// framing, parity, backpressure and reset cases, one at CLKS_PER_BIT=4 for
// bit timing.
module tb_parity_frame_tx;

  logic       clk;
  logic       rst;

  logic       v1, odd1, rdy1, tx1, busy1, done1;
  logic [7:0] d1;
  logic       v2, odd2, rdy2, tx2, busy2, done2;
  logic [7:0] d2;

  int unsigned tests;
  int unsigned fails;

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v1),
    .in_data    (d1),
    .par_odd    (odd1),
    .in_ready   (rdy1),
    .tx_out     (tx1),
    .busy       (busy1),
    .frame_done (done1)
  );

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v2),
    .in_data    (d2),
    .par_odd    (odd2),
    .in_ready   (rdy2),
    .tx_out     (tx2),
    .busy       (busy2),
    .frame_done (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after the accepting edge; checks the 11 line cycles of a
  // CLKS_PER_BIT=1 frame on DUT1.  p is the hand-computed parity bit.
  task automatic check_frame(input string name, input logic [7:0] d, input logic p);
    logic exp_tx;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1)       exp_tx = 1'b0;
      else if (i <= 9)  exp_tx = d[i-2];
      else if (i == 10) exp_tx = p;
      else              exp_tx = 1'b1;
      check($sformatf("%s tx c%0d", name, i), {31'd0, tx1}, {31'd0, exp_tx});
      check($sformatf("%s done c%0d", name, i), {31'd0, done1}, (i == 11) ? 32'd1 : 32'd0);
      check($sformatf("%s busy c%0d", name, i), {31'd0, busy1}, 32'd1);
    end
  endtask

  // Offer a word on DUT1 at a negedge, let it be accepted, then check the frame.
  task automatic send1(input string name, input logic [7:0] d, input logic odd, input logic p);
    @(negedge clk);
    v1 = 1'b1; d1 = d; odd1 = odd;
    #1 check({name, " ready"}, {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1 v1 = 1'b0;
    check_frame(name, d, p);
    @(negedge clk);
    check({name, " idle tx"}, {31'd0, tx1}, 32'd1);
    check({name, " idle ready"}, {31'd0, rdy1}, 32'd1);
    check({name, " idle done"}, {31'd0, done1}, 32'd0);
  endtask

  initial begin
    int unsigned busy_cnt;
    int unsigned done_cnt;
    logic        exp2;
    tests = 0; fails = 0;
    rst = 1'b1;
    v1 = 1'b0; d1 = '0; odd1 = 1'b0;
    v2 = 1'b0; d2 = '0; odd2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst tx", {31'd0, tx1}, 32'd1);
    check("rst busy", {31'd0, busy1}, 32'd0);
    check("rst done", {31'd0, done1}, 32'd0);
    check("rst ready", {31'd0, rdy1}, 32'd0);
    check("rst tx2", {31'd0, tx2}, 32'd1);
    rst = 1'b0;
    #1 check("post-rst ready", {31'd0, rdy1}, 32'd1);

    // Framing and parity sense
    send1("A5 odd", 8'hA5, 1'b1, 1'b1);
    send1("07 even", 8'h07, 1'b0, 1'b1);
    send1("07 odd", 8'h07, 1'b1, 1'b0);
    send1("00 odd", 8'h00, 1'b1, 1'b1);

    // Backpressure: second word queued, parity sense and data changed mid-frame
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h3C; odd1 = 1'b0;
    @(posedge clk);
    #1 d1 = 8'hC3; odd1 = 1'b1;
    check_frame("bp 3C", 8'h3C, 1'b0);
    @(negedge clk);
    check("bp gap tx", {31'd0, tx1}, 32'd1);
    check("bp gap busy", {31'd0, busy1}, 32'd0);
    check("bp gap ready", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1 v1 = 1'b0;
    check_frame("bp C3", 8'hC3, 1'b1);
    @(negedge clk);

    // Reset during data bit 3
    v1 = 1'b1; d1 = 8'hFF; odd1 = 1'b0;
    @(posedge clk);
    #1 v1 = 1'b0;
    repeat (5) @(negedge clk);
    check("mid tx bit3", {31'd0, tx1}, 32'd1);
    check("mid busy", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst tx", {31'd0, tx1}, 32'd1);
    check("mid rst busy", {31'd0, busy1}, 32'd0);
    check("mid rst done", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mid after %0d done", i), {31'd0, done1}, 32'd0);
      check($sformatf("mid after %0d tx", i), {31'd0, tx1}, 32'd1);
    end
    send1("5A odd", 8'h5A, 1'b1, 1'b1);

    // Reset and in_valid together
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; d1 = 8'h96; odd1 = 1'b0;
    #1 check("prio ready", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    check("prio busy", {31'd0, busy1}, 32'd0);
    check("prio tx", {31'd0, tx1}, 32'd1);
    rst = 1'b0;
    #1 check("prio ready after", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1 v1 = 1'b0;
    check_frame("prio 96", 8'h96, 1'b0);

    // Bit timing at CLKS_PER_BIT=4
    @(negedge clk);
    v2 = 1'b1; d2 = 8'hFF; odd2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (busy2) busy_cnt++;
      if (done2) begin
        done_cnt++;
        check("t4 done cycle", c, 44);
      end
      // start for 4 cycles, then data/parity/stop are all 1, then idle 1
      exp2 = (c <= 4) ? 1'b0 : 1'b1;
      check($sformatf("t4 tx c%0d", c), {31'd0, tx2}, {31'd0, exp2});
    end
    check("t4 busy cycles", busy_cnt, 44);
    check("t4 done count", done_cnt, 1);
    check("t4 ready end", {31'd0, rdy2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
